// File: rtl/addsub_acc_nbits.sv
// Registered WIDTH-bit two's-complement add/sub with running accumulator, optional
// saturation, valid/ready handshake on both sides and a sticky overflow flag.
module addsub_acc_nbits #(
   parameter int WIDTH = 8,
   parameter bit SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg,
   output logic             ovf_sticky
);

   localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   // On overflow the wrapped sign is the inverse of the true sign, so it picks the rail.
   function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] r,
                                                         input logic                    ovf_in);
      if (SAT && ovf_in)
         saturate = r[WIDTH-1] ? SMAX : SMIN;
      else
         saturate = r;
   endfunction

   logic signed [WIDTH-1:0] acc_p1;
   logic signed [WIDTH-1:0] acc_x_p0;
   logic signed [WIDTH-1:0] x_p0;
   logic signed [WIDTH-1:0] y_p0;
   logic signed [WIDTH-1:0] yinv_p0;
   logic signed [WIDTH-1:0] r_p0;
   logic signed [WIDTH-1:0] s_p0;
   logic        [WIDTH:0]   sum_p0;
   logic                    sub_p0;
   logic                    ovf_p0;
   logic                    accept_p0;

   logic signed [WIDTH-1:0] s_p1;
   logic                    vld_p1;
   logic                    cout_p1;
   logic                    ovf_p1;
   logic                    zero_p1;
   logic                    neg_p1;
   logic                    sticky_p1;

   // ---- stage p0: operand select and arithmetic on the offered op ----
   assign in_ready  = !rst && (!vld_p1 || out_ready);
   assign accept_p0 = in_valid && in_ready;

   // A same-cycle clear makes an accumulate op start from zero.
   assign acc_x_p0 = acc_clr ? '0 : acc_p1;
   assign x_p0     = op[1] ? acc_x_p0 : $signed(a);
   assign y_p0     = op[1] ? $signed(a) : $signed(b);
   assign sub_p0   = op[0];
   assign yinv_p0  = y_p0 ^ {WIDTH{sub_p0}};
   assign sum_p0   = {1'b0, x_p0} + {1'b0, yinv_p0} + {{WIDTH{1'b0}}, sub_p0};
   assign r_p0     = sum_p0[WIDTH-1:0];
   assign ovf_p0   = (x_p0[WIDTH-1] == (y_p0[WIDTH-1] ^ sub_p0)) &&
                     (r_p0[WIDTH-1] != x_p0[WIDTH-1]);
   assign s_p0     = saturate(r_p0, ovf_p0);

   // ---- stage p1: single output register, accumulator and sticky flag ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         s_p1      <= '0;
         cout_p1   <= 1'b0;
         ovf_p1    <= 1'b0;
         zero_p1   <= 1'b0;
         neg_p1    <= 1'b0;
         sticky_p1 <= 1'b0;
         acc_p1    <= '0;
      end else begin
         if (accept_p0) begin
            vld_p1  <= 1'b1;
            s_p1    <= s_p0;
            cout_p1 <= sum_p0[WIDTH];
            ovf_p1  <= ovf_p0;
            zero_p1 <= (s_p0 == '0);
            neg_p1  <= s_p0[WIDTH-1];
         end else if (out_ready) begin
            vld_p1  <= 1'b0;
         end

         if (accept_p0 && op[1])
            acc_p1 <= s_p0;
         else if (acc_clr)
            acc_p1 <= '0;

         if (accept_p0)
            sticky_p1 <= (sticky_p1 && !acc_clr) || ovf_p0;
         else if (acc_clr)
            sticky_p1 <= 1'b0;
      end
   end

   assign out_valid  = vld_p1;
   assign s          = s_p1;
   assign cout       = cout_p1;
   assign ovf        = ovf_p1;
   assign zero       = zero_p1;
   assign neg        = neg_p1;
   assign ovf_sticky = sticky_p1;

endmodule

// File: tb/tb_addsub_acc_nbits.sv
// Bench for addsub_acc_nbits: wrapping and saturating instances share stimulus; a
// negedge monitor pushes expected results on accept and pops them on consume.
module tb_addsub_acc_nbits;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic [1:0] op = 2'b00;
   logic       acc_clr = 1'b0;
   logic       out_ready = 1'b1;

   logic       in_ready, out_valid, cout, ovf, zero, neg, ovf_sticky;
   logic [7:0] s;
   logic       in_ready1, out_valid1, cout1, ovf1, zero1, neg1, ovf_sticky1;
   logic [7:0] s1;

   int checks = 0;
   int errors = 0;
   int npop   = 0;

   typedef struct packed {
      logic [7:0] s;
      logic       cout;
      logic       ovf;
      logic       zero;
      logic       neg;
   } res_t;

   typedef struct packed {
      res_t r0;
      res_t r1;
   } exp_t;

   exp_t       q[$];
   logic [7:0] macc0 = 8'h00;
   logic [7:0] macc1 = 8'h00;

   always #5 clk = ~clk;

   addsub_acc_nbits #(.WIDTH(8), .SAT(1'b0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .op(op), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready), .s(s),
      .cout(cout), .ovf(ovf), .zero(zero), .neg(neg), .ovf_sticky(ovf_sticky)
   );

   addsub_acc_nbits #(.WIDTH(8), .SAT(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
      .op(op), .acc_clr(acc_clr), .out_valid(out_valid1), .out_ready(out_ready), .s(s1),
      .cout(cout1), .ovf(ovf1), .zero(zero1), .neg(neg1), .ovf_sticky(ovf_sticky1)
   );

   // Reference built from integer arithmetic: true signed result range and unsigned borrow.
   function automatic res_t model(input logic [7:0] x, input logic [7:0] y,
                                  input logic sub, input bit sat);
      res_t r;
      int   sx, sy, t, ux, uy;
      sx = int'($signed(x));
      sy = int'($signed(y));
      ux = int'(x);
      uy = int'(y);
      t  = sub ? sx - sy : sx + sy;
      r.ovf  = (t > 127) || (t < -128);
      r.cout = sub ? (ux >= uy) : ((ux + uy) > 255);
      if (sat && r.ovf)
         r.s = (t > 127) ? 8'h7F : 8'h80;
      else
         r.s = t[7:0];
      r.zero = (r.s == 8'h00);
      r.neg  = r.s[7];
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         macc0 = 8'h00;
         macc1 = 8'h00;
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            npop++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_underflow got s=%h with no expected result queued", s);
            end else begin
               exp_t e;
               e = q.pop_front();
               if ({s, cout, ovf, zero, neg} !== e.r0 || {s1, cout1, ovf1, zero1, neg1} !== e.r1) begin
                  errors++;
                  $display("FAIL scoreboard_result got wrap=%h/%b%b%b%b sat=%h/%b%b%b%b exp wrap=%h/%b%b%b%b sat=%h/%b%b%b%b",
                           s, cout, ovf, zero, neg, s1, cout1, ovf1, zero1, neg1,
                           e.r0.s, e.r0.cout, e.r0.ovf, e.r0.zero, e.r0.neg,
                           e.r1.s, e.r1.cout, e.r1.ovf, e.r1.zero, e.r1.neg);
               end
            end
         end
         if (acc_clr) begin
            macc0 = 8'h00;
            macc1 = 8'h00;
         end
         if (in_valid && in_ready) begin
            exp_t e;
            e.r0 = model(op[1] ? macc0 : a, op[1] ? a : b, op[0], 1'b0);
            e.r1 = model(op[1] ? macc1 : a, op[1] ? a : b, op[0], 1'b1);
            q.push_back(e);
            if (op[1]) begin
               macc0 = e.r0.s;
               macc1 = e.r1.s;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic clr);
      op = o; a = aa; b = bb; acc_clr = clr; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; acc_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({in_ready, out_valid, s, ovf_sticky, in_ready1, out_valid1, ovf_sticky1} !== 13'b0) begin
         errors++;
         $display("FAIL reset_state got rdy=%b v=%b s=%h st=%b sat(rdy=%b v=%b st=%b) exp all 0",
                  in_ready, out_valid, s, ovf_sticky, in_ready1, out_valid1, ovf_sticky1);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got %b exp 1", in_ready);
      end
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      send(2'b00, 8'hFF, 8'h01, 1'b0);
      checks++;
      if ({out_valid, s, cout, ovf, zero, neg} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL add_ff_01 got v=%b s=%h c=%b o=%b z=%b n=%b exp v=1 s=00 c=1 o=0 z=1 n=0",
                  out_valid, s, cout, ovf, zero, neg);
      end
      send(2'b00, 8'h7F, 8'h01, 1'b0);
      checks++;
      if ({s, ovf, neg, cout, ovf_sticky} !== {8'h80, 1'b1, 1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL add_7f_01_wrap got s=%h o=%b n=%b c=%b st=%b exp s=80 o=1 n=1 c=0 st=1",
                  s, ovf, neg, cout, ovf_sticky);
      end
      checks++;
      if ({s1, ovf1, ovf_sticky1} !== {8'h7F, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL add_7f_01_sat got s=%h o=%b st=%b exp s=7f o=1 st=1", s1, ovf1, ovf_sticky1);
      end
   endtask

   task automatic test_sub();
      send(2'b01, 8'h80, 8'h01, 1'b0);
      checks++;
      if ({s, ovf, cout} !== {8'h7F, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL sub_80_01 got s=%h o=%b c=%b exp s=7f o=1 c=1", s, ovf, cout);
      end
      send(2'b01, 8'h6C, 8'hCA, 1'b0);
      checks++;
      if ({s, ovf, cout} !== {8'hA2, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sub_6c_ca got s=%h o=%b c=%b exp s=a2 o=1 c=0", s, ovf, cout);
      end
      checks++;
      if (s1 !== 8'h7F) begin
         errors++;
         $display("FAIL sub_6c_ca_sat got s=%h exp 7f", s1);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      tick();
      base = npop;
      out_ready = 1'b0;
      op = 2'b00; a = 8'h01; b = 8'h02; in_valid = 1'b1;
      tick();
      a = 8'h10; b = 8'h20;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({out_valid, s, in_ready} !== {1'b1, 8'h03, 1'b0}) begin
            errors++;
            $display("FAIL backpressure_hold got v=%b s=%h rdy=%b exp v=1 s=03 rdy=0",
                     out_valid, s, in_ready);
         end
      end
      out_ready = 1'b1;
      tick();
      op = 2'b01; a = 8'h05; b = 8'h03;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if ({out_valid, s} !== {1'b0, 8'h02}) begin
         errors++;
         $display("FAIL drain_retain got v=%b s=%h exp v=0 s=02", out_valid, s);
      end
      checks++;
      if (npop - base !== 3) begin
         errors++;
         $display("FAIL drain_count got %0d exp 3", npop - base);
      end
   endtask

   task automatic test_accumulate();
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL clr_sticky got %b exp 0", ovf_sticky);
      end
      send(2'b10, 8'h10, 8'hAA, 1'b0);
      send(2'b10, 8'h20, 8'h55, 1'b0);
      send(2'b10, 8'h30, 8'h00, 1'b0);
      checks++;
      if (s !== 8'h60) begin
         errors++;
         $display("FAIL acc_sum got s=%h exp 60", s);
      end
      send(2'b11, 8'h60, 8'h00, 1'b0);
      checks++;
      if ({s, zero} !== {8'h00, 1'b1}) begin
         errors++;
         $display("FAIL acc_sub_zero got s=%h z=%b exp s=00 z=1", s, zero);
      end
      send(2'b10, 8'h11, 8'h00, 1'b0);
      send(2'b10, 8'h05, 8'h00, 1'b1);
      checks++;
      if (s !== 8'h05) begin
         errors++;
         $display("FAIL acc_clr_same_cycle got s=%h exp 05", s);
      end
   endtask

   task automatic test_reset_midop();
      out_ready = 1'b1;
      send(2'b00, 8'h7F, 8'h01, 1'b0);
      out_ready = 1'b0;
      send(2'b10, 8'h07, 8'h00, 1'b0);
      rst = 1'b1;
      tick();
      checks++;
      if ({out_valid, s, ovf_sticky, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_midop got v=%b s=%h st=%b rdy=%b exp v=0 s=00 st=0 rdy=0",
                  out_valid, s, ovf_sticky, in_ready);
      end
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      send(2'b10, 8'h05, 8'h00, 1'b0);
      checks++;
      if (s !== 8'h05) begin
         errors++;
         $display("FAIL reset_acc_cleared got s=%h exp 05", s);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_accumulate();
      test_reset_midop();
      tick();
      tick();
      checks++;
      if (q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d exp 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
